// File: rtl/ahb3lite_sram_slave.sv
// rtl/ahb3lite_sram_slave.sv - AHB3-Lite SRAM slave with wait states and two-cycle ERROR response
module ahb3lite_sram_slave #(
    parameter int HADDR_SIZE  = 32,
    parameter int HDATA_SIZE  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [HADDR_SIZE-1:0] HADDR,
    input  logic [HDATA_SIZE-1:0] HWDATA,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [1:0]            HTRANS,
    input  logic                  HREADY,
    output logic [HDATA_SIZE-1:0] HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP
);

    localparam int                    LP_AW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [HADDR_SIZE-1:0] LP_DEPTH = HADDR_SIZE'(MEM_DEPTH);
    localparam logic [3:0]            LP_WAIT  = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_ERR1 = 2'd2,
        S_ERR2 = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_nxt;
    logic [LP_AW-1:0]      r_widx;
    logic [1:0]            r_lane;
    logic [2:0]            r_size;
    logic                  r_write;
    logic [HDATA_SIZE-1:0] r_mem [MEM_DEPTH];

    logic                  w_final;
    logic                  w_accept;
    logic                  w_misaligned;
    logic                  w_out_of_range;
    logic                  w_illegal;
    logic                  w_wr_en;
    logic [3:0]            w_be;
    logic [HADDR_SIZE-1:0] w_word_addr;
    logic                  w_hreadyout;
    logic                  w_hresp;
    logic                  w_unused;

    // Burst type, protection and the SEQ/NONSEQ distinction do not affect an SRAM.
    assign w_unused = ^{HBURST, HPROT, HTRANS[0]};

    assign w_word_addr    = {2'b00, HADDR[HADDR_SIZE-1:2]};
    assign w_out_of_range = (w_word_addr >= LP_DEPTH);
    assign w_final        = (r_state == S_DATA) && (r_cnt == 4'd0);

    // Alignment check of the address-phase address against the requested size.
    always_comb begin
        w_misaligned = 1'b0;
        case (HSIZE)
            3'd1:    w_misaligned = HADDR[0];
            3'd2:    w_misaligned = |HADDR[1:0];
            default: w_misaligned = 1'b0;
        endcase
    end

    assign w_illegal = (HSIZE > 3'd2) | w_misaligned | w_out_of_range;

    // A new address phase can only overlap the last cycle of the previous data phase.
    assign w_accept = HSEL & HREADY & HTRANS[1] &
                      ((r_state == S_IDLE) | w_final | (r_state == S_ERR2));

    // Next-state, wait counter and response outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_hreadyout = 1'b1;
        w_hresp     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_IDLE;
            end
            S_DATA: begin
                if (r_cnt != 4'd0) begin
                    w_cnt_nxt   = r_cnt - 4'd1;
                    w_hreadyout = 1'b0;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ERR1: begin
                w_hreadyout = 1'b0;
                w_hresp     = 1'b1;
                w_state_nxt = S_ERR2;
            end
            S_ERR2: begin
                w_hresp     = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (w_accept) begin
            w_state_nxt = w_illegal ? S_ERR1 : S_DATA;
            w_cnt_nxt   = w_illegal ? 4'd0 : LP_WAIT;
        end
    end

    // State, counter and captured address-phase controls.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_widx  <= '0;
            r_lane  <= 2'd0;
            r_size  <= 3'd0;
            r_write <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_widx  <= HADDR[LP_AW+1:2];
                r_lane  <= HADDR[1:0];
                r_size  <= HSIZE;
                r_write <= HWRITE;
            end
        end
    end

    // Little-endian byte-lane enables for the captured size and offset.
    always_comb begin
        w_be = 4'b0000;
        case (r_size)
            3'd0:    w_be[r_lane] = 1'b1;
            3'd1:    w_be = r_lane[1] ? 4'b1100 : 4'b0011;
            default: w_be = 4'b1111;
        endcase
    end

    assign w_wr_en = w_final & r_write;

    // Memory array is not reset; a reset forces IDLE so an aborted write never lands.
    always_ff @(posedge HCLK) begin
        if (w_wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[r_widx][8*i +: 8] <= HWDATA[8*i +: 8];
                end
            end
        end
    end

    assign HRDATA    = (w_final && !r_write) ? r_mem[r_widx] : '0;
    assign HREADYOUT = w_hreadyout;
    assign HRESP     = w_hresp;

endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// tb/tb_ahb3lite_sram_slave.sv - scoreboard bench for ahb3lite_sram_slave
module tb_ahb3lite_sram_slave;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hsel, hwrite, sel_dut, force_low;
    logic [31:0] haddr, hwdata;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;
    logic [1:0]  htrans;
    logic [31:0] hrdata0, hrdata2;
    logic        rdy0, rdy2, hresp0, hresp2;
    logic        hsel0, hsel2, bus_hready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign hsel0      = hsel & ~sel_dut;
    assign hsel2      = hsel & sel_dut;
    assign bus_hready = force_low ? 1'b0 : (sel_dut ? rdy2 : rdy0);

    ahb3lite_sram_slave #(.WAIT_STATES(0)) u_dut0 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel0), .HADDR(haddr), .HWDATA(hwdata),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HTRANS(htrans),
        .HREADY(bus_hready), .HRDATA(hrdata0), .HREADYOUT(rdy0), .HRESP(hresp0)
    );

    ahb3lite_sram_slave #(.WAIT_STATES(2)) u_dut2 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel2), .HADDR(haddr), .HWDATA(hwdata),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HTRANS(htrans),
        .HREADY(bus_hready), .HRDATA(hrdata2), .HREADYOUT(rdy2), .HRESP(hresp2)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [31:0] erd;
        logic        eresp;
        int          ewaits;
    } xfer_t;

    xfer_t seq[$];
    xfer_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void add(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                                input logic [31:0] wdata, input logic [31:0] erd,
                                input logic eresp, input int ewaits);
        xfer_t x;
        x.wr = wr; x.addr = addr; x.size = size; x.wdata = wdata;
        x.erd = erd; x.eresp = eresp; x.ewaits = ewaits;
        seq.push_back(x);
    endfunction

    // Pipelined driver: address of the next transfer overlaps the data phase of the previous.
    task automatic run_seq();
        xfer_t cur, prev;
        bit    have_cur, have_prev, r;
        int    budget;
        have_prev = 0;
        @(posedge clk); #1;
        while (seq.size() > 0 || have_prev) begin
            if (seq.size() > 0) begin
                cur = seq.pop_front();
                have_cur = 1;
                hsel = 1'b1; htrans = 2'b10; haddr = cur.addr; hwrite = cur.wr; hsize = cur.size;
                exp_q.push_back(cur);
            end else begin
                have_cur = 0;
                hsel = 1'b0; htrans = 2'b00;
            end
            hwdata = (have_prev && prev.wr) ? prev.wdata : 32'h0;
            budget = 0;
            do begin
                @(negedge clk); r = bus_hready;
                @(posedge clk); #1;
                budget++;
            end while (!r && budget < 50);
            if (!r) begin
                checks++; errors++;
                $display("FAIL hready_timeout: got HREADY=0 after %0d cycles expected 1", budget);
                seq.delete();
                have_cur = 0;
                hsel = 1'b0; htrans = 2'b00;
            end
            prev = cur;
            have_prev = have_cur;
        end
        hwdata = 32'h0;
    endtask

    // Monitor: counts wait cycles of each data phase and scores it when HREADYOUT rises.
    bit    pend = 0;
    bit    pend_dut = 0;
    int    waits = 0;
    always @(negedge clk) begin
        xfer_t e;
        if (!rst_n) begin
            pend  = 0;
            waits = 0;
        end else begin
            if (pend) begin
                if (pend_dut ? !rdy2 : !rdy0) begin
                    waits++;
                end else begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_response: got a completed data phase expected none");
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("hrdata@%h", e.addr), pend_dut ? hrdata2 : hrdata0, e.erd);
                        check($sformatf("hresp@%h", e.addr), {31'b0, pend_dut ? hresp2 : hresp0}, {31'b0, e.eresp});
                        check($sformatf("waits@%h", e.addr), 32'(waits), 32'(e.ewaits));
                    end
                    pend  = 0;
                    waits = 0;
                end
            end
            if (hsel && bus_hready && htrans[1]) begin
                pend     = 1;
                pend_dut = sel_dut;
            end
        end
    end

    initial begin
        rst_n = 1'b0; hsel = 0; hwrite = 0; sel_dut = 0; force_low = 0;
        haddr = 0; hwdata = 0; hsize = 3'd2; hburst = 0; hprot = 0; htrans = 0;
        #1;
        check("reset_hreadyout0", {31'b0, rdy0}, 32'd1);
        check("reset_hresp0", {31'b0, hresp0}, 32'd0);
        check("reset_hrdata0", hrdata0, 32'h0);
        check("reset_hreadyout2", {31'b0, rdy2}, 32'd1);
        check("reset_hresp2", {31'b0, hresp2}, 32'd0);
        check("reset_hrdata2", hrdata2, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk); #2 rst_n = 1'b1;

        // Zero-wait write then back-to-back read of the same word.
        sel_dut = 0;
        add(1, 32'h10, 3'd2, 32'hDEADBEEF, 32'h0, 0, 0);
        add(0, 32'h10, 3'd2, 32'h0, 32'hDEADBEEF, 0, 0);
        // Byte lanes with garbage in the unselected lanes, then halfword overwrite.
        add(1, 32'h20, 3'd0, 32'hEEEEEE11, 32'h0, 0, 0);
        add(1, 32'h21, 3'd0, 32'hEEEE22EE, 32'h0, 0, 0);
        add(1, 32'h22, 3'd0, 32'hEE33EEEE, 32'h0, 0, 0);
        add(1, 32'h23, 3'd0, 32'h44EEEEEE, 32'h0, 0, 0);
        add(0, 32'h20, 3'd2, 32'h0, 32'h44332211, 0, 0);
        add(1, 32'h22, 3'd1, 32'hAABBEEEE, 32'h0, 0, 0);
        add(0, 32'h20, 3'd2, 32'h0, 32'hAABB2211, 0, 0);
        // Last legal word, then illegal transfers back-to-back, then memory unchanged.
        add(1, 32'h3FC, 3'd2, 32'h5A5AA5A5, 32'h0, 0, 0);
        add(1, 32'h00, 3'd2, 32'h01020304, 32'h0, 0, 0);
        add(0, 32'h400, 3'd2, 32'h0, 32'h0, 1, 1);
        add(1, 32'h02, 3'd2, 32'hFFFFFFFF, 32'h0, 1, 1);
        add(1, 32'h10, 3'd3, 32'h12345678, 32'h0, 1, 1);
        add(1, 32'h01, 3'd1, 32'hFFFFFFFF, 32'h0, 1, 1);
        add(0, 32'h00, 3'd2, 32'h0, 32'h01020304, 0, 0);
        add(0, 32'h10, 3'd2, 32'h0, 32'hDEADBEEF, 0, 0);
        add(0, 32'h3FC, 3'd2, 32'h0, 32'h5A5AA5A5, 0, 0);
        run_seq();

        // Two wait states per data phase.
        sel_dut = 1;
        add(1, 32'h40, 3'd2, 32'hCAFEF00D, 32'h0, 0, 2);
        add(0, 32'h40, 3'd2, 32'h0, 32'hCAFEF00D, 0, 2);
        run_seq();

        // Reset in the middle of a waited write data phase.
        @(posedge clk); #1;
        hsel = 1; htrans = 2'b10; haddr = 32'h40; hwrite = 1; hsize = 3'd2;
        @(negedge clk);
        @(posedge clk); #1;
        hsel = 0; htrans = 2'b00; hwdata = 32'h0BADC0DE;
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("abort_hreadyout", {31'b0, rdy2}, 32'd1);
        check("abort_hresp", {31'b0, hresp2}, 32'd0);
        check("abort_hrdata", hrdata2, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk); #2 rst_n = 1'b1;
        hwdata = 32'h0;
        add(0, 32'h40, 3'd2, 32'h0, 32'hCAFEF00D, 0, 2);
        run_seq();

        // NONSEQ presented while HREADY is low must be ignored.
        @(posedge clk); #1;
        force_low = 1; hsel = 1; htrans = 2'b10; haddr = 32'h40; hwrite = 0; hsize = 3'd2;
        @(posedge clk); #1;
        htrans = 2'b00; force_low = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("ignored_hreadyout_%0d", i), {31'b0, rdy2}, 32'd1);
            check($sformatf("ignored_hrdata_%0d", i), hrdata2, 32'h0);
        end
        hsel = 0;

        repeat (2) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("no_pending_phase", {31'b0, pend}, 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb3lite_sram_slave.md
AHB3LITE_SRAM_SLAVE -- requirements
Module: ahb3lite_sram_slave

Interface
REQ-001 SHALL have parameter HADDR_SIZE, default 32, address width.
REQ-002 SHALL have parameter HDATA_SIZE, default 32, data width (only 32 supported).
REQ-003 SHALL have parameter MEM_DEPTH, default 256, memory size in 32-bit words.
REQ-004 SHALL have parameter WAIT_STATES, default 0 (range 0..15), HREADYOUT-low cycles inserted per OKAY data phase.
REQ-005 SHALL have HCLK  input  1  sole clock, rising edge.
REQ-006 SHALL have HRESETn  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have HSEL  input  1  slave select.
REQ-008 SHALL have HADDR  input  HADDR_SIZE  byte address.
REQ-009 SHALL have HWDATA  input  HDATA_SIZE  write data (data phase).
REQ-010 SHALL have HWRITE  input  1  1=write, 0=read.
REQ-011 SHALL have HSIZE  input  3  transfer size.
REQ-012 SHALL have HBURST  input  3  burst type (ignored).
REQ-013 SHALL have HPROT  input  4  protection (ignored).
REQ-014 SHALL have HTRANS  input  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
REQ-015 SHALL have HREADY  input  1  bus-level ready (previous transfer complete).
REQ-016 SHALL have HRDATA  output  HDATA_SIZE  read data.
REQ-017 SHALL have HREADYOUT  output  1  this slave's ready.
REQ-018 SHALL have HRESP  output  1  0=OKAY, 1=ERROR.

Function
REQ-019 SHALL accept an address phase only when HSEL=1, HREADY=1 and HTRANS[1]=1 at a rising HCLK edge; it SHALL register HADDR, HWRITE and HSIZE.
REQ-020 SHALL answer IDLE/BUSY, unselected, or HREADY=0 cycles with no state change; HREADYOUT=1, HRESP=0 when no data phase is pending.
REQ-021 SHALL use FSM states IDLE, DATA, ERR1, ERR2; an accepted transfer enters DATA (legal) or ERR1 (illegal).
REQ-022 SHALL classify a transfer as illegal if HSIZE>2, if HADDR is not aligned to HSIZE, or if HADDR[HADDR_SIZE-1:2] >= MEM_DEPTH.
REQ-023 In DATA, a counter loaded with WAIT_STATES SHALL hold HREADYOUT=0, HRESP=0 while nonzero and decrement each cycle; at zero, HREADYOUT=1, HRESP=0 (final cycle).
REQ-024 ERROR response SHALL be two cycles: ERR1 drives HREADYOUT=0, HRESP=1; ERR2 drives HREADYOUT=1, HRESP=1; no memory access occurs.
REQ-025 Writes SHALL update memory at the edge ending the final DATA cycle using HWDATA, enabling only the lanes selected by HSIZE and HADDR[1:0], little-endian (byte: lane HADDR[1:0]; halfword: lanes 2*HADDR[1] and +1; word: all).
REQ-026 Reads SHALL drive the full addressed word on HRDATA during the final DATA cycle; HRDATA SHALL be 0 at all other times.
REQ-027 A new address phase accepted in the final DATA cycle or in ERR2 SHALL go to DATA/ERR1 next without an idle cycle (pipelined back-to-back); otherwise the FSM SHALL return to IDLE.
REQ-028 A read immediately following a write to the same word SHALL return the newly written data.
REQ-029 Address/control inputs SHALL be ignored while HREADY=0.
REQ-030 Slave SHALL NOT assert HREADYOUT=0 in any state other than DATA-with-count>0 and ERR1.

Reset
REQ-031 Asserting HRESETn=0 SHALL immediately force FSM=IDLE, counter=0, HREADYOUT=1, HRESP=0, HRDATA=0, including mid-transfer; the aborted write SHALL NOT modify memory.
REQ-032 Memory contents SHALL NOT be reset.
REQ-033 First address phase SHALL be sampled at the first rising edge after HRESETn deasserts.

Verification
REQ-034 WAIT_STATES=0: NONSEQ word write 0xDEADBEEF to 0x10, then NONSEQ read 0x10 back-to-back -> HREADYOUT=1 throughout, HRDATA=0xDEADBEEF in read data phase, HRESP=0.
REQ-035 Byte writes 0x11,0x22,0x33,0x44 to 0x20..0x23, halfword write 0xAABB to 0x22, word read 0x20 -> HRDATA=0xAABB2211.
REQ-036 WAIT_STATES=2: single read -> exactly 2 cycles HREADYOUT=0 then 1 cycle HREADYOUT=1 with data.
REQ-037 Read to 0x400 (MEM_DEPTH=256), word access at 0x02, and HSIZE=3 each -> ERR1 (HREADYOUT=0,HRESP=1) then ERR2 (HREADYOUT=1,HRESP=1); memory unchanged.
REQ-038 Assert HRESETn low during a WAIT_STATES=2 write data phase -> outputs go to HREADYOUT=1,HRESP=0,HRDATA=0 without a clock edge; later read shows old word.
REQ-039 HSEL=1, HTRANS=NONSEQ with HREADY=0, then HTRANS=IDLE -> no transfer accepted, HREADYOUT stays 1.
